// File: rtl/stopwatch_time_ctrl.sv
// Stopwatch time register block: owns MM:SS in BCD, applies clear, adjust and
// free-run count updates in priority order, and generates the blink/blank
// qualifiers for the display driver. All outputs are registered.
module stopwatch_time_ctrl #(
    parameter int unsigned MIN_MAX = 59,
    parameter int unsigned SEC_MAX = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic       use_1hz,
    input  logic       use_2hz,
    input  logic       count_enable,
    input  logic       sel_minutes,
    input  logic       sel_seconds,
    input  logic       blink_enable,
    input  logic       clear,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       blink_phase,
    output logic       blank_min,
    output logic       blank_sec,
    output logic       rollover
);

    // Both maxima fit in 7 bits (<= 99).
    localparam logic [6:0] MinMax = 7'(MIN_MAX);
    localparam logic [6:0] SecMax = 7'(SEC_MAX);

    // Blink state lives in blink_phase: SHOW = 0, HIDE = 1.
    typedef enum logic [0:0] {
        StShow = 1'b0,
        StHide = 1'b1
    } blink_state_e;

    // Binary value of a two-digit BCD field.
    function automatic logic [6:0] bcd_value(input logic [3:0] tens, input logic [3:0] ones);
        return ({3'b000, tens} * 7'd10) + {3'b000, ones};
    endfunction

    // BCD +1 with wrap to 00 once the full value reaches max_val. The >=
    // keeps the field legal even if it ever held an out-of-range value.
    function automatic logic [7:0] bcd_inc(input logic [3:0] tens, input logic [3:0] ones,
                                           input logic [6:0] max_val);
        logic [7:0] res;
        if (bcd_value(tens, ones) >= max_val) begin
            res = 8'h00;
        end else if (ones >= 4'd9) begin
            res = {tens + 4'd1, 4'd0};
        end else begin
            res = {tens, ones + 4'd1};
        end
        return res;
    endfunction

    logic [3:0]   min_tens_q, min_tens_d;
    logic [3:0]   min_ones_q, min_ones_d;
    logic [3:0]   sec_tens_q, sec_tens_d;
    logic [3:0]   sec_ones_q, sec_ones_d;
    logic         rollover_q, rollover_d;
    blink_state_e blink_q, blink_d;
    logic         blank_min_q, blank_min_d;
    logic         blank_sec_q, blank_sec_d;

    logic       adjust_evt;
    logic       count_evt;
    logic       sec_at_max;
    logic       min_at_max;
    logic [7:0] sec_inc;
    logic [7:0] min_inc;

    assign adjust_evt = tick_2hz & use_2hz & (sel_minutes ^ sel_seconds);
    assign count_evt  = tick_1hz & use_1hz & count_enable;

    assign sec_at_max = (bcd_value(sec_tens_q, sec_ones_q) >= SecMax);
    assign min_at_max = (bcd_value(min_tens_q, min_ones_q) >= MinMax);
    assign sec_inc    = bcd_inc(sec_tens_q, sec_ones_q, SecMax);
    assign min_inc    = bcd_inc(min_tens_q, min_ones_q, MinMax);

    // Time next-state: clear > adjust > count; rollover only on a count wrap.
    always_comb begin
        min_tens_d = min_tens_q;
        min_ones_d = min_ones_q;
        sec_tens_d = sec_tens_q;
        sec_ones_d = sec_ones_q;
        rollover_d = 1'b0;
        if (clear) begin
            min_tens_d = 4'd0;
            min_ones_d = 4'd0;
            sec_tens_d = 4'd0;
            sec_ones_d = 4'd0;
        end else if (adjust_evt) begin
            if (sel_minutes) begin
                {min_tens_d, min_ones_d} = min_inc;
            end else begin
                {sec_tens_d, sec_ones_d} = sec_inc;
            end
        end else if (count_evt) begin
            {sec_tens_d, sec_ones_d} = sec_inc;
            if (sec_at_max) begin
                {min_tens_d, min_ones_d} = min_inc;
                rollover_d = min_at_max;
            end
        end
    end

    // Blink next-state and blank qualifiers, computed from the next phase so
    // blanking lines up with the phase register.
    always_comb begin
        blink_d = blink_q;
        if (clear || !blink_enable) begin
            blink_d = StShow;
        end else if (tick_2hz) begin
            blink_d = (blink_q == StShow) ? StHide : StShow;
        end
        blank_min_d = blink_enable & sel_minutes & (blink_d == StHide);
        blank_sec_d = blink_enable & sel_seconds & (blink_d == StHide);
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            min_tens_q  <= 4'd0;
            min_ones_q  <= 4'd0;
            sec_tens_q  <= 4'd0;
            sec_ones_q  <= 4'd0;
            rollover_q  <= 1'b0;
            blink_q     <= StShow;
            blank_min_q <= 1'b0;
            blank_sec_q <= 1'b0;
        end else begin
            min_tens_q  <= min_tens_d;
            min_ones_q  <= min_ones_d;
            sec_tens_q  <= sec_tens_d;
            sec_ones_q  <= sec_ones_d;
            rollover_q  <= rollover_d;
            blink_q     <= blink_d;
            blank_min_q <= blank_min_d;
            blank_sec_q <= blank_sec_d;
        end
    end

    assign min_tens    = min_tens_q;
    assign min_ones    = min_ones_q;
    assign sec_tens    = sec_tens_q;
    assign sec_ones    = sec_ones_q;
    assign rollover    = rollover_q;
    assign blink_phase = (blink_q == StHide);
    assign blank_min   = blank_min_q;
    assign blank_sec   = blank_sec_q;

endmodule

// File: tb/tb_stopwatch_time_ctrl.sv
// Self-checking bench for stopwatch_time_ctrl: an integer-level model of the
// stopwatch checked against the DUT every cycle, plus directed literal checks.
module tb_stopwatch_time_ctrl;

    localparam int MIN_MAX = 59;
    localparam int SEC_MAX = 59;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_1hz = 1'b0, tick_2hz = 1'b0;
    logic       use_1hz = 1'b0, use_2hz = 1'b0;
    logic       count_enable = 1'b0;
    logic       sel_minutes = 1'b0, sel_seconds = 1'b0;
    logic       blink_enable = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       blink_phase, blank_min, blank_sec, rollover;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model state: plain minutes/seconds integers and flags.
    int m_min = 0, m_sec = 0;
    bit m_ph = 0, m_bm = 0, m_bs = 0, m_ro = 0;

    stopwatch_time_ctrl #(
        .MIN_MAX(MIN_MAX),
        .SEC_MAX(SEC_MAX)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick_1hz    (tick_1hz),
        .tick_2hz    (tick_2hz),
        .use_1hz     (use_1hz),
        .use_2hz     (use_2hz),
        .count_enable(count_enable),
        .sel_minutes (sel_minutes),
        .sel_seconds (sel_seconds),
        .blink_enable(blink_enable),
        .clear       (clear),
        .min_tens    (min_tens),
        .min_ones    (min_ones),
        .sec_tens    (sec_tens),
        .sec_ones    (sec_ones),
        .blink_phase (blink_phase),
        .blank_min   (blank_min),
        .blank_sec   (blank_sec),
        .rollover    (rollover)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on each edge from the inputs sampled there.
    always @(posedge clk) begin
        if (rst) begin
            m_min = 0; m_sec = 0; m_ph = 0; m_bm = 0; m_bs = 0; m_ro = 0;
        end else begin
            m_ro = 0;
            if (clear) begin
                m_min = 0; m_sec = 0;
            end else if (tick_2hz && use_2hz && (sel_minutes != sel_seconds)) begin
                if (sel_minutes) m_min = (m_min == MIN_MAX) ? 0 : m_min + 1;
                else             m_sec = (m_sec == SEC_MAX) ? 0 : m_sec + 1;
            end else if (tick_1hz && use_1hz && count_enable) begin
                if (m_sec == SEC_MAX) begin
                    m_sec = 0;
                    if (m_min == MIN_MAX) begin
                        m_min = 0;
                        m_ro  = 1;
                    end else begin
                        m_min = m_min + 1;
                    end
                end else begin
                    m_sec = m_sec + 1;
                end
            end
            if (clear || !blink_enable) m_ph = 0;
            else if (tick_2hz)          m_ph = !m_ph;
            m_bm = blink_enable && sel_minutes && m_ph;
            m_bs = blink_enable && sel_seconds && m_ph;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_min_tens", int'(min_tens), m_min / 10);
            chk("cyc_min_ones", int'(min_ones), m_min % 10);
            chk("cyc_sec_tens", int'(sec_tens), m_sec / 10);
            chk("cyc_sec_ones", int'(sec_ones), m_sec % 10);
            chk("cyc_blink_phase", int'(blink_phase), int'(m_ph));
            chk("cyc_blank_min", int'(blank_min), int'(m_bm));
            chk("cyc_blank_sec", int'(blank_sec), int'(m_bs));
            chk("cyc_rollover", int'(rollover), int'(m_ro));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick1();
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
    endtask

    task automatic tick2();
        tick_2hz = 1'b1;
        step();
        tick_2hz = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    // Literal MM:SS check on the DUT, and on the model to pin it.
    task automatic check_time(input string name, input int mm, input int ss);
        chk({name, "_dut"}, int'(min_tens) * 1000 + int'(min_ones) * 100 +
            int'(sec_tens) * 10 + int'(sec_ones), mm * 100 + ss);
        chk({name, "_model"}, m_min * 100 + m_sec, mm * 100 + ss);
    endtask

    task automatic set_time(input int mm, input int ss);
        do_clear();
        use_1hz = 1'b0;
        use_2hz = 1'b1;
        sel_minutes = 1'b1;
        sel_seconds = 1'b0;
        repeat (mm) tick2();
        sel_minutes = 1'b0;
        sel_seconds = 1'b1;
        repeat (ss) tick2();
        sel_seconds = 1'b0;
        use_2hz = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset held for two cycles.
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        step();
        check_time("reset_time", 0, 0);
        chk("reset_phase", int'(blink_phase), 0);
        chk("reset_blanks", int'({blank_min, blank_sec}), 0);
        chk("reset_rollover", int'(rollover), 0);
        rst = 1'b0;

        // Free-run count of three seconds.
        use_1hz = 1'b1;
        count_enable = 1'b1;
        repeat (3) tick1();
        check_time("run3", 0, 3);

        // Second-to-minute carry.
        set_time(0, 59);
        check_time("preload_0059", 0, 59);
        use_1hz = 1'b1;
        tick1();
        check_time("carry_0100", 1, 0);
        chk("carry_no_rollover", int'(rollover), 0);

        // Full wrap with a single-cycle rollover pulse.
        set_time(59, 59);
        check_time("preload_5959", 59, 59);
        use_1hz = 1'b1;
        tick1();
        check_time("wrap_0000", 0, 0);
        chk("wrap_rollover", int'(rollover), 1);
        step();
        chk("wrap_rollover_drop", int'(rollover), 0);

        // Seconds adjust wraps with no carry.
        set_time(0, 58);
        use_1hz = 1'b0;
        use_2hz = 1'b1;
        sel_seconds = 1'b1;
        tick2(); check_time("adj_sec_59", 0, 59);
        tick2(); check_time("adj_sec_00", 0, 0);
        chk("adj_sec_no_rollover", int'(rollover), 0);
        tick2(); check_time("adj_sec_01", 0, 1);
        sel_seconds = 1'b0;

        // Minutes adjust wraps, seconds untouched.
        set_time(58, 7);
        use_2hz = 1'b1;
        sel_minutes = 1'b1;
        tick2(); check_time("adj_min_59", 59, 7);
        tick2(); check_time("adj_min_00", 0, 7);
        tick2(); check_time("adj_min_01", 1, 7);
        sel_minutes = 1'b0;
        use_2hz = 1'b0;

        // Blink on minutes: phase 1,0,1,0 with blank_min following.
        do_clear();
        use_2hz = 1'b1;
        sel_minutes = 1'b1;
        blink_enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick2();
            chk("blink_phase_seq", int'(blink_phase), (i % 2 == 0) ? 1 : 0);
            chk("blink_blank_min", int'(blank_min), (i % 2 == 0) ? 1 : 0);
            chk("blink_blank_sec", int'(blank_sec), 0);
        end
        check_time("blink_adjusted", 4, 0);
        tick2();
        chk("blink_hide_again", int'(blink_phase), 1);
        blink_enable = 1'b0;
        step();
        chk("blink_forced_show", int'(blink_phase), 0);
        chk("blink_forced_unblank", int'(blank_min), 0);
        sel_minutes = 1'b0;
        use_2hz = 1'b0;

        // Pause holds the digits.
        set_time(12, 34);
        use_1hz = 1'b1;
        count_enable = 1'b0;
        repeat (5) tick1();
        check_time("pause_hold", 12, 34);

        // Clear overrides a coincident count tick.
        count_enable = 1'b1;
        clear = 1'b1;
        tick1();
        clear = 1'b0;
        check_time("clear_over_tick", 0, 0);
        chk("clear_rollover", int'(rollover), 0);

        // Both selects set: adjust suppressed.
        set_time(0, 5);
        use_1hz = 1'b0;
        use_2hz = 1'b1;
        sel_minutes = 1'b1;
        sel_seconds = 1'b1;
        tick2();
        check_time("illegal_sel_hold", 0, 5);
        sel_minutes = 1'b0;

        // Reset mid-blink returns everything to reset values.
        blink_enable = 1'b1;
        tick2();
        chk("midblink_blank_sec", int'(blank_sec), 1);
        check_time("midblink_time", 0, 6);
        rst = 1'b1;
        step();
        check_time("midblink_reset_time", 0, 0);
        chk("midblink_reset_phase", int'(blink_phase), 0);
        chk("midblink_reset_blanks", int'({blank_min, blank_sec}), 0);
        rst = 1'b0;
        blink_enable = 1'b0;
        sel_seconds = 1'b0;
        use_2hz = 1'b0;
        step();
        step();

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
